mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter XLEN, default 32, data/address datapath width; multiple of 8.
REQ-002 Parameter MADDR_W, default 8, word-address width toward data memory.
REQ-003 Parameter PC_W, default 8, branch-target width.
REQ-004 Parameter CTRL_W, default 34, width of the writeback control bundle passed through.
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  EX/MEM slot holds a valid instruction.
REQ-008 in_ctrl  in  CTRL_W  writeback control bundle, passed through unmodified.
REQ-009 in_mem_read, in_mem_write, in_branch  in  1 each  memory-read, memory-write and branch controls.
REQ-010 in_funct3  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; same codes for sb/sh/sw.
REQ-011 in_zero  in  1  ALU zero flag.
REQ-012 in_alu_result, in_store_data  in  XLEN each  effective address and unaligned store data.
REQ-013 in_pc_branch  in  PC_W  branch target.
REQ-014 mem_req, mem_we  out  1 each  memory request and write strobe.
REQ-015 mem_addr  out  MADDR_W  word address = in_alu_result[MADDR_W+1:2].
REQ-016 mem_be  out  XLEN/8  byte enables; mem_wdata  out  XLEN  lane-aligned store data.
REQ-017 mem_ack  in  1  memory done; mem_rdata  in  XLEN  read word, valid when mem_ack=1.
REQ-018 stall  out  1  freeze upstream stages and hold in_* stable.
REQ-019 out_valid, out_ctrl, out_alu_result, out_load_data  out  1/CTRL_W/XLEN/XLEN  MEM/WB register.
REQ-020 pc_select  out  1 and pc_branch  out  PC_W  registered branch redirect.
REQ-021 misalign_err  out  1  registered one-cycle pulse on a misaligned access.

Function
REQ-022 FSM states IDLE and WAIT; reset state IDLE.
REQ-023 IDLE, in_valid with read or write, aligned: mem_req=1 combinationally; mem_ack same cycle -> retire that edge; else -> WAIT with stall=1.
REQ-024 WAIT: mem_req=1, stall=1, address/be/wdata held; mem_ack -> retire, -> IDLE, stall=0 that cycle.
REQ-025 Non-memory valid instruction retires in IDLE in one cycle, mem_req=0, stall=0.
REQ-026 Retire: out_valid=1; out_ctrl, out_alu_result, pc_branch loaded; pc_select=in_branch & in_zero.
REQ-027 Cycles without retire: out_valid=0, pc_select=0; other MEM/WB fields hold.
REQ-028 Alignment: halfword needs addr[0]=0, word needs addr[1:0]=00.
REQ-029 Misaligned access: no mem_req, retires in one cycle with out_valid=1, misalign_err=1, ctrl bundle zeroed.
REQ-030 Store lanes: sb -> be=0001<<addr[1:0], data byte replicated; sh -> be=0011<<addr[1:0], half replicated; sw -> be=1111.
REQ-031 Load extract: select byte/half by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend to XLEN, registered into out_load_data.
REQ-032 Reserved funct3 on a memory op: treated as word access.
REQ-033 in_mem_read and in_mem_write both set: write takes priority.
REQ-034 Latency: 1 cycle for ack-in-cycle or non-memory op; N+1 cycles when ack arrives N cycles after the request.

Reset
REQ-035 reset dominates all inputs, including a mem_ack in the same cycle; FSM -> IDLE.
REQ-036 Reset values: all outputs 0; mem_req/stall 0 from the following cycle; an in-flight request is abandoned and its late ack ignored.

Structure
REQ-037 Shared package: funct3 access-size constants and FSM state encoding.
REQ-038 One sub-module, mem_lane_align: combinational store lane steering plus load extract and extend.

Verification
REQ-039 sw 0xDEADBEEF @0x10, ack same cycle -> mem_be=1111, mem_addr=4, out_valid next edge, stall never 1.
REQ-040 lb @0x13, rdata 0x80FF0000, ack after 3 cycles -> stall 3 cycles, out_load_data=0xFFFFFF80; lbu -> 0x00000080.
REQ-041 sh 0x1234 @0x02 -> mem_be=1100, mem_wdata=0x12341234.
REQ-042 lw @0x06 -> mem_req=0, misalign_err=1, out_ctrl=0, single cycle.
REQ-043 branch, zero=1, target 0x2C -> pc_select=1, pc_branch=0x2C next edge; zero=0 -> pc_select=0.
REQ-044 reset in WAIT with simultaneous mem_ack -> IDLE, out_valid=0, stall=0 next cycle.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage:
// funct3 access codes, access-size decode and FSM state encoding.
package mem_access_stage_pkg;

    // funct3 codes for loads; stores reuse the same size codes.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Reserved codes fall through to a full-word access.
    function automatic acc_size_t decode_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: decode_size = SZ_BYTE;
            F3_H, F3_HU: decode_size = SZ_HALF;
            F3_W:        decode_size = SZ_WORD;
            default:     decode_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic load_signed(input logic [2:0] funct3);
        load_signed = (funct3 == F3_B) || (funct3 == F3_H);
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and memory (slave).
// Handshake: the master holds mem_req and all request fields stable until
// the cycle in which the slave raises mem_ack; mem_rdata is valid only in
// that cycle, and the transfer completes on the following clock edge.
interface mem_access_stage_if #(
    parameter int XLEN    = 32,
    parameter int MADDR_W = 8
);
    logic                 mem_req;
    logic                 mem_we;
    logic [MADDR_W-1:0]   mem_addr;
    logic [XLEN/8-1:0]    mem_be;
    logic [XLEN-1:0]      mem_wdata;
    logic                 mem_ack;
    logic [XLEN-1:0]      mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extract / extension for loads.
// Purely combinational; the byte offset selects the active lane(s).
module mem_lane_align
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]        off,
    input  acc_size_t         size,
    input  logic              sign_ext,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_data
);
    localparam int NB = XLEN / 8;

    logic [4:0]      shamt;
    logic [XLEN-1:0] rd_shift;

    assign shamt    = {off, 3'b000};
    assign rd_shift = rdata >> shamt;

    // Store lanes are replicated so the byte enables alone pick the target bytes.
    always_comb begin
        be        = '1;
        wdata     = store_data;
        load_data = rdata;
        case (size)
            SZ_BYTE: begin
                be        = NB'(1) << off;
                wdata     = {NB{store_data[7:0]}};
                load_data = {{(XLEN-8){sign_ext & rd_shift[7]}}, rd_shift[7:0]};
            end
            SZ_HALF: begin
                be        = NB'(3) << off;
                wdata     = {(XLEN/16){store_data[15:0]}};
                load_data = {{(XLEN-16){sign_ext & rd_shift[15]}}, rd_shift[15:0]};
            end
            default: begin
                be        = '1;
                wdata     = store_data;
                load_data = rdata;
            end
        endcase
    end
endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage: issues data-memory requests, stalls the
// upstream pipe until acknowledged, and loads the MEM/WB register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MADDR_W = 8,
    parameter int PC_W    = 8,
    parameter int CTRL_W  = 34
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [CTRL_W-1:0]   in_ctrl,
    input  logic                in_mem_read,
    input  logic                in_mem_write,
    input  logic                in_branch,
    input  logic [2:0]          in_funct3,
    input  logic                in_zero,
    input  logic [XLEN-1:0]     in_alu_result,
    input  logic [XLEN-1:0]     in_store_data,
    input  logic [PC_W-1:0]     in_pc_branch,
    mem_access_stage_if.master  mem,
    output logic                stall,
    output logic                out_valid,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic [XLEN-1:0]     out_alu_result,
    output logic [XLEN-1:0]     out_load_data,
    output logic                pc_select,
    output logic [PC_W-1:0]     pc_branch,
    output logic                misalign_err,
    output state_t              dbg_state
);
    state_t          state_q, state_d;
    acc_size_t       size;
    logic [1:0]      off;
    logic            misaligned;
    logic            mem_op;
    logic            bad_access;
    logic            is_load;
    logic            req_c;
    logic            stall_c;
    logic            retire;
    logic [XLEN-1:0] load_data;

    assign size       = decode_size(in_funct3);
    assign off        = in_alu_result[1:0];
    assign misaligned = ((size == SZ_HALF) && off[0]) ||
                        ((size == SZ_WORD) && (off != 2'b00));
    assign mem_op     = in_valid & (in_mem_read | in_mem_write);
    assign bad_access = mem_op & misaligned;
    // A write wins when both controls are set.
    assign is_load    = in_mem_read & ~in_mem_write;

    mem_lane_align #(.XLEN(XLEN)) u_lane_align (
        .off        (off),
        .size       (size),
        .sign_ext   (load_signed(in_funct3)),
        .store_data (in_store_data),
        .rdata      (mem.mem_rdata),
        .be         (mem.mem_be),
        .wdata      (mem.mem_wdata),
        .load_data  (load_data)
    );

    // Request fields come straight from in_*, which upstream holds while stalled.
    assign mem.mem_req  = req_c;
    assign mem.mem_we   = req_c & in_mem_write;
    assign mem.mem_addr = in_alu_result[MADDR_W+1:2];
    assign stall        = stall_c;
    assign dbg_state    = state_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, request/stall and retire decision.
    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        stall_c = 1'b0;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (mem_op && !misaligned) begin
                        req_c = 1'b1;
                        if (mem.mem_ack) begin
                            retire = 1'b1;
                        end else begin
                            stall_c = 1'b1;
                            state_d = ST_WAIT;
                        end
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                req_c = 1'b1;
                if (mem.mem_ack) begin
                    retire  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // MEM/WB register: pulses clear every cycle, payload only moves on retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_ctrl       <= '0;
            out_alu_result <= '0;
            out_load_data  <= '0;
            pc_select      <= 1'b0;
            pc_branch      <= '0;
            misalign_err   <= 1'b0;
        end else begin
            out_valid    <= retire;
            pc_select    <= retire & in_branch & in_zero;
            misalign_err <= retire & bad_access;
            if (retire) begin
                out_ctrl       <= bad_access ? '0 : in_ctrl;
                out_alu_result <= in_alu_result;
                pc_branch      <= in_pc_branch;
            end
            if (retire && req_c && is_load) begin
                out_load_data <= load_data;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [33:0]       in_ctrl;
    logic              in_mem_read;
    logic              in_mem_write;
    logic              in_branch;
    logic [2:0]        in_funct3;
    logic              in_zero;
    logic [31:0]       in_alu_result;
    logic [31:0]       in_store_data;
    logic [7:0]        in_pc_branch;
    logic              stall;
    logic              out_valid;
    logic [33:0]       out_ctrl;
    logic [31:0]       out_alu_result;
    logic [31:0]       out_load_data;
    logic              pc_select;
    logic [7:0]        pc_branch;
    logic              misalign_err;
    state_t            dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_load;

    mem_access_stage_if #(.XLEN(32), .MADDR_W(8)) bus ();

    mem_access_stage #(.XLEN(32), .MADDR_W(8), .PC_W(8), .CTRL_W(34)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ctrl        (in_ctrl),
        .in_mem_read    (in_mem_read),
        .in_mem_write   (in_mem_write),
        .in_branch      (in_branch),
        .in_funct3      (in_funct3),
        .in_zero        (in_zero),
        .in_alu_result  (in_alu_result),
        .in_store_data  (in_store_data),
        .in_pc_branch   (in_pc_branch),
        .mem            (bus.master),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_ctrl       (out_ctrl),
        .out_alu_result (out_alu_result),
        .out_load_data  (out_load_data),
        .pc_select      (pc_select),
        .pc_branch      (pc_branch),
        .misalign_err   (misalign_err),
        .dbg_state      (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic rd, input logic wr, input logic br,
                             input logic [2:0] f3, input logic z, input logic [31:0] alu,
                             input logic [31:0] sd, input logic [7:0] pcb, input logic [33:0] ctrl);
        in_valid = v; in_mem_read = rd; in_mem_write = wr; in_branch = br;
        in_funct3 = f3; in_zero = z; in_alu_result = alu; in_store_data = sd;
        in_pc_branch = pcb; in_ctrl = ctrl;
    endtask

    task automatic clear_instr();
        set_instr(0, 0, 0, 0, 3'b000, 0, 32'h0, 32'h0, 8'h0, 34'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_instr();
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_ctrl !== 34'h0) begin errors++; $display("FAIL reset_out_ctrl got %h exp 0", out_ctrl); end
        checks++; if (out_load_data !== 32'h0) begin errors++; $display("FAIL reset_load got %h exp 0", out_load_data); end
        checks++; if (pc_select !== 1'b0 || pc_branch !== 8'h0) begin errors++; $display("FAIL reset_pc got %b/%h exp 0/00", pc_select, pc_branch); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign_err); end
        checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_req_stall got %b/%b exp 0/0", bus.mem_req, stall); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        reset = 1'b0;
    endtask

    task automatic test_sw_same_cycle();
        set_instr(1, 0, 1, 0, F3_W, 0, 32'h10, 32'hDEADBEEF, 8'h0, 34'h2_1234_5678);
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL sw_req_we got %b/%b exp 1/1", bus.mem_req, bus.mem_we); end
        checks++; if (bus.mem_addr !== 8'h04) begin errors++; $display("FAIL sw_addr got %h exp 04", bus.mem_addr); end
        checks++; if (bus.mem_be !== 4'b1111) begin errors++; $display("FAIL sw_be got %b exp 1111", bus.mem_be); end
        checks++; if (bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", bus.mem_wdata); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sw_stall got %b exp 0", stall); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sw_out_valid got %b exp 1", out_valid); end
        checks++; if (out_ctrl !== 34'h2_1234_5678) begin errors++; $display("FAIL sw_out_ctrl got %h exp 212345678", out_ctrl); end
        checks++; if (out_alu_result !== 32'h10) begin errors++; $display("FAIL sw_out_alu got %h exp 10", out_alu_result); end
        clear_instr();
        bus.mem_ack = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sw_idle_valid got %b exp 0", out_valid); end
        checks++; if (out_ctrl !== 34'h2_1234_5678) begin errors++; $display("FAIL sw_ctrl_hold got %h exp 212345678", out_ctrl); end
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input int n, input logic [31:0] exp_data);
        int stall_cnt;
        stall_cnt = 0;
        set_instr(1, 1, 0, 0, f3, 0, addr, 32'h0, 8'h0, 34'h1);
        bus.mem_rdata = rdata;
        for (int c = 0; c <= n; c++) begin
            bus.mem_ack = (c == n);
            #1;
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL %s_req got %b/%b exp 1/0", name, bus.mem_req, bus.mem_we); end
            if (stall === 1'b1) stall_cnt++;
            @(posedge clk); #1;
            if (c < n) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid got %b exp 0", name, out_valid); end
            end
        end
        checks++; if (stall_cnt != n) begin errors++; $display("FAIL %s_stall_cycles got %0d exp %0d", name, stall_cnt, n); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b exp 1", name, out_valid); end
        checks++; if (out_load_data !== exp_data) begin errors++; $display("FAIL %s_data got %h exp %h", name, out_load_data, exp_data); end
        last_load = exp_data;
        clear_instr();
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        step();
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        set_instr(1, 0, 1, 0, f3, 0, addr, data, 8'h0, 34'h3);
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.mem_be !== exp_be) begin errors++; $display("FAIL %s_be got %b exp %b", name, bus.mem_be, exp_be); end
        checks++; if (bus.mem_wdata !== exp_wdata) begin errors++; $display("FAIL %s_wdata got %h exp %h", name, bus.mem_wdata, exp_wdata); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b exp 1", name, out_valid); end
        clear_instr();
        bus.mem_ack = 1'b0;
        step();
    endtask

    task automatic test_rw_priority();
        set_instr(1, 1, 1, 0, F3_W, 0, 32'h08, 32'h5555AAAA, 8'h0, 34'h7);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h99999999;
        #1;
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rw_we got %b exp 1", bus.mem_we); end
        @(posedge clk); #1;
        checks++; if (out_load_data !== last_load) begin errors++; $display("FAIL rw_load_hold got %h exp %h", out_load_data, last_load); end
        clear_instr();
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        step();
    endtask

    task automatic test_misalign();
        set_instr(1, 1, 0, 0, F3_W, 0, 32'h06, 32'h0, 8'h0, 34'h3_FFFF_0001);
        bus.mem_ack = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL mis_lw_req_stall got %b/%b exp 0/0", bus.mem_req, stall); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || misalign_err !== 1'b1) begin errors++; $display("FAIL mis_lw_valid_err got %b/%b exp 1/1", out_valid, misalign_err); end
        checks++; if (out_ctrl !== 34'h0) begin errors++; $display("FAIL mis_lw_ctrl got %h exp 0", out_ctrl); end
        checks++; if (out_alu_result !== 32'h06) begin errors++; $display("FAIL mis_lw_alu got %h exp 6", out_alu_result); end
        set_instr(1, 0, 1, 0, F3_H, 0, 32'h03, 32'h1234, 8'h0, 34'h5);
        #1;
        checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL mis_sh_req_we got %b/%b exp 0/0", bus.mem_req, bus.mem_we); end
        @(posedge clk); #1;
        checks++; if (misalign_err !== 1'b1 || out_ctrl !== 34'h0) begin errors++; $display("FAIL mis_sh_err_ctrl got %b/%h exp 1/0", misalign_err, out_ctrl); end
        clear_instr();
        step();
        checks++; if (misalign_err !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mis_pulse_end got %b/%b exp 0/0", misalign_err, out_valid); end
    endtask

    task automatic test_branch();
        set_instr(1, 0, 0, 1, 3'b000, 1, 32'h0, 32'h0, 8'h2C, 34'h9);
        #1;
        checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL br_req_stall got %b/%b exp 0/0", bus.mem_req, stall); end
        @(posedge clk); #1;
        checks++; if (pc_select !== 1'b1 || pc_branch !== 8'h2C) begin errors++; $display("FAIL br_taken got %b/%h exp 1/2c", pc_select, pc_branch); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL br_valid got %b exp 1", out_valid); end
        set_instr(1, 0, 0, 1, 3'b000, 0, 32'h0, 32'h0, 8'h40, 34'h9);
        step();
        checks++; if (pc_select !== 1'b0 || pc_branch !== 8'h40) begin errors++; $display("FAIL br_not_taken got %b/%h exp 0/40", pc_select, pc_branch); end
        clear_instr();
        step();
        checks++; if (pc_select !== 1'b0 || pc_branch !== 8'h40 || out_valid !== 1'b0) begin errors++; $display("FAIL br_idle got %b/%h/%b exp 0/40/0", pc_select, pc_branch, out_valid); end
    endtask

    task automatic test_reset_in_wait();
        set_instr(1, 1, 0, 0, F3_W, 0, 32'h08, 32'h0, 8'h0, 34'hF);
        bus.mem_ack = 1'b0;
        step();
        checks++; if (dbg_state !== ST_WAIT || stall !== 1'b1) begin errors++; $display("FAIL rw_wait_entry got %0d/%b exp 1/1", dbg_state, stall); end
        reset = 1'b1;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h13572468;
        step();
        reset = 1'b0;
        clear_instr();
        bus.mem_ack = 1'b0;
        #1;
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_wait_state got %0d exp 0", dbg_state); end
        checks++; if (out_valid !== 1'b0 || stall !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_wait_outs got %b/%b/%b exp 0/0/0", out_valid, stall, bus.mem_req); end
        checks++; if (out_load_data !== 32'h0 || out_ctrl !== 34'h0) begin errors++; $display("FAIL rst_wait_regs got %h/%h exp 0/0", out_load_data, out_ctrl); end
        bus.mem_ack = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL late_ack_valid got %b exp 0", out_valid); end
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    // Test sequence and summary
    initial begin
        last_load = 32'h0;
        test_reset();
        test_sw_same_cycle();
        test_load("lb",  F3_B,  32'h13, 32'h80FF0000, 3, 32'hFFFFFF80);
        test_load("lbu", F3_BU, 32'h13, 32'h80FF0000, 3, 32'h00000080);
        test_load("lh",  F3_H,  32'h02, 32'h80011234, 0, 32'hFFFF8001);
        test_load("lhu", F3_HU, 32'h02, 32'h80011234, 1, 32'h00008001);
        test_load("lw",  F3_W,  32'h04, 32'h12345678, 2, 32'h12345678);
        test_store("sh",  F3_H,   32'h02, 32'h00001234, 4'b1100, 32'h12341234);
        test_store("sb",  F3_B,   32'h01, 32'h000000AB, 4'b0010, 32'hABABABAB);
        test_store("rsv", 3'b011, 32'h04, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
        test_rw_priority();
        test_misalign();
        test_branch();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
